serial_frame_tx: RTL and testbench

- Parallel-to-serial framing stage that sits directly upstream of the serial XOR-accumulator/toggle stage and drives its single-bit input stream.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Can append a parity bit, so the downstream accumulator returns to a known value at every frame boundary.
- Emits frame-start and frame-end strobes so downstream logic can align its state per frame.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_frame_tx.sv | 124 ++++++++++++
 tb/tb_serial_frame_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial framing stage.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int PAR_MODE_EVEN = 0;
    localparam int PAR_MODE_ODD  = 1;

    // Counter must be able to hold every value from 0 up to the frame length.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: shifts WIDTH-bit words out one bit per clock,
// optionally followed by a parity bit, with frame start/end strobes.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = PAR_MODE_EVEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int FRAME_LEN = WIDTH + PARITY_EN;
    localparam int CNT_W     = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST  = CNT_W'(WIDTH - 1);
    localparam logic PARITY_SEED = (PARITY_ODD == PAR_MODE_ODD);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             parity_reg, parity_next;
    logic             x_reg, x_next;
    logic             x_valid_reg, x_valid_next;
    logic             frame_start_reg, frame_start_next;
    logic             frame_end_reg, frame_end_next;
    logic             last_bit;
    logic             load;

    // cnt_reg holds the number of frame bits already presented on x.
    assign last_bit = (PARITY_EN != 0) ? (state_reg == PAR)
                                       : (state_reg == SHIFT && cnt_reg == CNT_LAST_DATA);
    assign din_ready = (state_reg == IDLE || last_bit) && reset;
    assign load      = din_valid && din_ready;

    assign x           = x_reg;
    assign x_valid     = x_valid_reg;
    assign frame_start = frame_start_reg;
    assign frame_end   = frame_end_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            cnt_reg         <= '0;
            parity_reg      <= 1'b0;
            x_reg           <= 1'b0;
            x_valid_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            cnt_reg         <= cnt_next;
            parity_reg      <= parity_next;
            x_reg           <= x_next;
            x_valid_reg     <= x_valid_next;
            frame_start_reg <= frame_start_next;
            frame_end_reg   <= frame_end_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load) state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt_reg == CNT_LAST_DATA) begin
                    if (PARITY_EN != 0) state_next = PAR;
                    else                state_next = load ? SHIFT : IDLE;
                end
            end
            PAR: begin
                state_next = load ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        shift_next       = shift_reg;
        cnt_next         = cnt_reg;
        parity_next      = parity_reg;
        x_next           = 1'b0;
        x_valid_next     = 1'b0;
        frame_start_next = 1'b0;
        frame_end_next   = 1'b0;
        if (load) begin
            x_next           = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
            shift_next       = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
            cnt_next         = CNT_W'(1);
            parity_next      = (^din) ^ PARITY_SEED;
            x_valid_next     = 1'b1;
            frame_start_next = 1'b1;
        end else if (state_reg == SHIFT && cnt_reg != CNT_LAST_DATA) begin
            x_next         = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
            shift_next     = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
            cnt_next       = cnt_reg + 1'b1;
            x_valid_next   = 1'b1;
            frame_end_next = (PARITY_EN == 0) && (cnt_reg == CNT_PRE_LAST);
        end else if (state_reg == SHIFT && PARITY_EN != 0) begin
            x_next         = parity_reg;
            cnt_next       = cnt_reg + 1'b1;
            x_valid_next   = 1'b1;
            frame_end_next = 1'b1;
        end else begin
            shift_next = '0;
            cnt_next   = '0;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized check of serial_frame_tx in four configurations against a
// frame-level reference model (expected bit queue per configuration).
module tb_serial_frame_tx;

    localparam int NCFG = 4;
    localparam int CFG_W    [NCFG] = '{8, 8, 8, 2};
    localparam int CFG_MSB  [NCFG] = '{1, 1, 0, 1};
    localparam int CFG_PEN  [NCFG] = '{1, 1, 0, 0};
    localparam int CFG_ODD  [NCFG] = '{0, 1, 0, 0};
    localparam logic [7:0] DIR_WORDS [5] = '{8'hA5, 8'hFF, 8'h01, 8'h3C, 8'h81};

    logic clk;
    logic reset;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        chk_cnt++;
        if (obs !== expd) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expd, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W   = CFG_W[gi];
        localparam int MSB = CFG_MSB[gi];
        localparam int PEN = CFG_PEN[gi];
        localparam int ODD = CFG_ODD[gi];

        logic [W-1:0] din;
        logic         din_valid;
        logic         din_ready;
        logic         x;
        logic         x_valid;
        logic         frame_start;
        logic         frame_end;

        serial_frame_tx #(
            .WIDTH(W), .MSB_FIRST(MSB), .PARITY_EN(PEN), .PARITY_ODD(ODD)
        ) dut (
            .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
            .din_ready(din_ready), .x(x), .x_valid(x_valid),
            .frame_start(frame_start), .frame_end(frame_end)
        );

        // Each queue entry is {bit, first-of-frame, last-of-frame}.
        logic [2:0] exp_q[$];
        logic [2:0] cur;
        logic       cur_v;
        logic       exp_ready;
        logic       hs;
        logic       acc;
        int         nw;

        always @(negedge reset) begin
            #1;
            check($sformatf("cfg%0d async_reset", gi),
                  {27'b0, x, x_valid, frame_start, frame_end, din_ready}, 32'h0);
        end

        initial begin
            din       = W'(DIR_WORDS[0]);
            din_valid = 1'b1;
            nw        = 1;
            cur       = '0;
            cur_v     = 1'b0;
            acc       = 1'b0;
            forever begin
                @(negedge clk);
                if (!reset) begin
                    exp_q.delete();
                    cur_v = 1'b0;
                end
                exp_ready = reset && (!cur_v || cur[0]);
                check($sformatf("cfg%0d outputs", gi),
                      {27'b0, x, x_valid, frame_start, frame_end, din_ready},
                      {27'b0, cur_v & cur[2], cur_v, cur_v & cur[1], cur_v & cur[0], exp_ready});
                if (x_valid) begin
                    acc = frame_start ? x : (acc ^ x);
                    if (frame_end && PEN != 0)
                        check($sformatf("cfg%0d frame_xor", gi), {31'b0, acc}, ODD);
                end
                hs = din_valid && exp_ready;
                if (hs) begin
                    for (int k = 0; k < W; k++) begin
                        exp_q.push_back({(MSB != 0) ? din[W-1-k] : din[k],
                                         k == 0, (k == W - 1) && (PEN == 0)});
                    end
                    if (PEN != 0)
                        exp_q.push_back({((($countones(din) % 2) != 0) ^ (ODD != 0)), 1'b0, 1'b1});
                    $display("cfg%0d: word 0x%0h accepted at %0t", gi, din, $time);
                end
                @(posedge clk);
                #1;
                if (exp_q.size() > 0) begin
                    cur   = exp_q.pop_front();
                    cur_v = 1'b1;
                end else begin
                    cur_v = 1'b0;
                end
                if (!reset) begin
                    if (nw > 1) din = W'(8'h81);
                    din_valid = 1'b1;
                end else if (hs || !din_valid) begin
                    if (nw < 5) begin
                        din       = W'(DIR_WORDS[nw]);
                        din_valid = 1'b1;
                        nw++;
                    end else begin
                        din       = W'($urandom);
                        din_valid = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        end
    end

    initial begin
        logic found;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (300) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (g_cfg[0].frame_start) found = 1'b1;
        end
        check("reset_wait", {31'b0, found}, 32'h1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
